// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the N-input selector/arbiter.
// Mode encoding and one-hot to index conversion used by the round-robin arbiter.
package mux_arb_pkg;

  typedef enum logic {MODE_FIXED = 1'b0, MODE_RR = 1'b1} mux_mode_t;

  // Widest one-hot vector the helper accepts; callers zero-extend into it.
  localparam int MAX_N = 64;

  function automatic int onehot2idx(input logic [MAX_N-1:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_N; i++) begin
      if (oh[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/mux_arb_n_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester at or after rr_ptr,
// wrapping from N_IN-1 back to 0.
module rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int N_IN  = 4,
  parameter int SEL_W = $clog2(N_IN)
) (
  input  logic [N_IN-1:0]  in_valid,
  input  logic [SEL_W-1:0] rr_ptr,
  output logic             grant_valid,
  output logic [SEL_W-1:0] grant_idx
);

  logic [N_IN-1:0] w_grant_oh;

  always_comb begin
    int  k;
    logic found;
    k          = 0;
    found      = 1'b0;
    w_grant_oh = '0;
    for (int i = 0; i < N_IN; i++) begin
      k = int'(rr_ptr) + i;
      if (k >= N_IN) k = k - N_IN;
      if (!found && in_valid[k]) begin
        w_grant_oh[k] = 1'b1;
        found         = 1'b1;
      end
    end
  end

  assign grant_valid = |in_valid;
  assign grant_idx   = SEL_W'(onehot2idx(MAX_N'(w_grant_oh)));

endmodule

// File: rtl/mux_arb_n.sv
// N-input WIDTH-bit selector with fixed-select or round-robin grant and a
// one-entry registered output stage.
module mux_arb_n
  import mux_arb_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N_IN  = 4,
  parameter int SEL_W = $clog2(N_IN)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  input  logic [N_IN-1:0]       in_valid,
  input  logic [N_IN*WIDTH-1:0] in_data,
  output logic [N_IN-1:0]       in_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_src,
  input  logic                  out_ready
);

  // Handshake: a beat moves on any edge where valid & ready are both high on
  // that side; valid may not depend on ready, and a source holds valid/data
  // until it is accepted. The output register refills in the same cycle it drains.

  localparam int NPAD = 1 << SEL_W;

  logic               r_out_valid;
  logic [WIDTH-1:0]   r_out_data;
  logic [SEL_W-1:0]   r_out_src;
  logic [SEL_W-1:0]   r_rr_ptr;

  mux_mode_t          w_mode;
  logic               w_load_en;
  logic               w_rr_valid;
  logic [SEL_W-1:0]   w_rr_idx;
  logic [NPAD-1:0]    w_valid_pad;
  logic               w_grant_valid;
  logic [SEL_W-1:0]   w_grant_idx;
  logic               w_xfer;
  logic [WIDTH-1:0]   w_sel_data;

  assign w_mode    = mux_mode_t'(mode);
  assign w_load_en = ~r_out_valid | out_ready;

  rr_arbiter #(.N_IN(N_IN), .SEL_W(SEL_W)) u_rr_arbiter (
    .in_valid    (in_valid),
    .rr_ptr      (r_rr_ptr),
    .grant_valid (w_rr_valid),
    .grant_idx   (w_rr_idx)
  );

  // Padding to a power of two makes out-of-range sel values see a zero request.
  assign w_valid_pad = NPAD'(in_valid);

  always_comb begin
    w_grant_valid = 1'b0;
    w_grant_idx   = '0;
    if (w_mode == MODE_RR) begin
      w_grant_valid = w_rr_valid;
      w_grant_idx   = w_rr_idx;
    end else begin
      w_grant_valid = w_valid_pad[sel];
      w_grant_idx   = sel;
    end
  end

  assign w_xfer     = reset_n & w_load_en & w_grant_valid;
  assign in_ready   = w_xfer ? (N_IN'(1) << w_grant_idx) : '0;
  assign w_sel_data = in_data[int'(w_grant_idx)*WIDTH +: WIDTH];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= '0;
      r_rr_ptr    <= '0;
    end else begin
      if (w_load_en) begin
        r_out_valid <= w_xfer;
        if (w_xfer) begin
          r_out_data <= w_sel_data;
          r_out_src  <= w_grant_idx;
        end
      end
      if (w_xfer && (w_mode == MODE_RR)) begin
        r_rr_ptr <= (int'(w_grant_idx) == N_IN-1) ? '0 : w_grant_idx + SEL_W'(1);
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_src   = r_out_src;

endmodule
